btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Sequences all writes into the 8-set, 2-way branch target buffer storage array.
- Accepts resolved-branch updates from execute through a valid/ready handshake and performs a read-modify-write of the addressed set: hit update, allocation, 2-bit counter and LRU maintenance.
- Also runs a full-array invalidate (flush) walk.
- It is the only driver of the array's write_index, write_set, write_enable and update_index ports.

Parameters:
- IDX_W, 3, set index width (PC[4:2]); 2**IDX_W sets.
- TAG_W, 27, tag width (PC[31:5]).
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- upd_valid  in  1  branch-resolution update request
- upd_ready  out  1  controller can accept an update this cycle
- upd_pc  in  32  PC of resolved branch
- upd_target  in  32  resolved target
- upd_taken  in  1  resolved direction
- flush_req  in  1  single-cycle pulse requesting invalidate of all sets
- flush_done  out  1  one-cycle pulse when the flush walk completes
- busy  out  1  FSM not in IDLE
- update_index  out  IDX_W  set index to the array's update read port
- update_set  in  128  combinational set contents from the array
- write_index  out  IDX_W  array write index
- write_set  out  128  array write data
- write_enable  out  1  array write strobe

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Values during reset: state=IDLE; upd_ready=1; busy=0; flush_done=0; write_enable=0; write_index=0; write_set=0; update_index=0; flush counter=0; flush pending flag=0.
- Set layout:
  - way1=[127:64], way0=[63:0].
  - Per way: [63] valid, [62:61] ctr, [60:34] tag, [31:0] target; [33] and [32] reserved.
  - Way0 bit [32] is the set LRU bit (0 means way0 is the replacement victim); all other reserved bits are written as 0.
- FSM states: IDLE, LOOKUP, WRITE, FLUSH.
- IDLE:
  - upd_ready=1.
  - If the flush pending flag or flush_req is set: go to FLUSH with counter=0. Flush has priority, and upd_ready is forced to 0 that cycle.
  - Otherwise, on upd_valid&upd_ready: capture pc, target and taken, then go to LOOKUP.
- LOOKUP (1 cycle):
  - update_index=captured PC[4:2]; sample update_set.
  - Hit on way w when valid and tag==PC[31:5]. If both ways hit, way0 wins.
  - Hit:
    - ctr saturating +1 if taken, -1 if not taken (clamped at 3 and 0).
    - If taken, target is overwritten; if not taken, target is unchanged.
    - LRU is set to point at the other way.
  - Miss and taken:
    - Victim is the first invalid way (way0 first); if both ways are valid, the victim is the way selected by LRU.
    - Victim is written with valid=1, ctr=CTR_INIT, the new tag and the new target.
    - LRU is set to point at the other way.
  - Miss and not taken: no write; return to IDLE.
  - The computed set is registered into write_set/write_index; then go to WRITE.
- WRITE (1 cycle):
  - write_enable=1; the other way's bits pass through unchanged.
  - Return to IDLE.
- Update latency: accept at edge N, write strobe in cycle N+2, upd_ready high again in cycle N+3. Maximum throughput is one update per 3 cycles.
- FLUSH:
  - write_enable=1, write_set=0, write_index=counter each cycle; counter increments.
  - After index 2**IDX_W-1 is written: pulse flush_done for one cycle and return to IDLE.
  - The flush takes 8 cycles.
- flush_req arriving during LOOKUP/WRITE sets the pending flag. The in-flight update completes first, then the flush runs. The pending flag clears on entering FLUSH.
- flush_req arriving during FLUSH is absorbed, with no restart.
- upd_valid during a non-IDLE state is not accepted. The requester must hold its request stable until the handshake completes.
- busy=1 in LOOKUP, WRITE and FLUSH.
- The array's read port is untouched by this block. Same-cycle read/write forwarding is the array's job.
- Reset mid-operation: immediately IDLE, with no write strobe; any partial flush is lost. The array contents are unspecified until a new flush.

Test Plan:
- Flush then miss-taken: flush_req; 8 write strobes at indices 0..7, data 0; flush_done pulses. Then update pc=0x0000_1008, target=0x0000_2000, taken=1 → set 2 way0 = valid, ctr=2, tag=0x80, target=0x2000; LRU=1.
- Hit counter saturation: 3 taken updates to pc 0x1008 → ctr 2→3→3. Then 4 not-taken updates → 2,1,0,0, with target unchanged at 0x2000.
- Replacement: taken updates to 0x1008, 0x2008, then 0x3008 → 0x2008 fills way1. 0x3008 evicts way0 (LRU), leaving way1 intact; LRU then points at way1.
- Miss not-taken: update pc 0x4010, taken=0 on an empty set 4 → no write_enable pulse; upd_ready returns after 2 cycles.
- Flush collision: flush_req one cycle after an update handshake → update write at N+2 completes, then the 8-cycle flush follows; upd_ready stays 0 throughout.
- Async reset: assert rst mid-FLUSH (counter=3) → write_enable drops without waiting for a clock edge; busy=0, upd_ready=1, and no flush_done pulse.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
// Owns the write side of the 8-set, 2-way branch target buffer. Branch
// resolutions from execute arrive over a valid/ready handshake and are applied
// as a read-modify-write of one set (hit update or allocation, 2-bit counter
// and LRU upkeep). A flush request walks every set and writes it to zero.
//
// Set layout: way1 = [127:64], way0 = [63:0].
// Each way holds: [63] valid, [62:61] counter, [60:34] tag, [33:32] reserved,
// [31:0] target. Way0 bit [32] is the set LRU bit: it names the next victim
// (0 selects way0, 1 selects way1).

module btb_update_ctrl #(
  parameter int         IDX_W    = 3,
  parameter int         TAG_W    = 27,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     update_index,
  input  logic [127:0]         update_set,
  output logic [IDX_W-1:0]     write_index,
  output logic [127:0]         write_set,
  output logic                 write_enable
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [IDX_W-1:0]   r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_target;
  logic               r_taken;

  logic [IDX_W-1:0]   r_flushCnt;
  logic               r_flushPend;
  logic               r_flushDone;

  logic [IDX_W-1:0]   r_writeIndex;
  logic [127:0]       r_writeSet;

  logic               w_accept;
  logic               w_startFlush;
  logic               w_flushLast;

  logic [63:0]        w_way0;
  logic [63:0]        w_way1;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_needWrite;
  logic               w_writeWay;
  logic [63:0]        w_oldEntry;
  logic [1:0]         w_ctr;
  logic [31:0]        w_newTarget;
  logic [63:0]        w_newEntry;
  logic [127:0]       w_newSet;

  // The two low PC bits never select anything in the BTB.
  logic               w_unusedPcLsb;
  assign w_unusedPcLsb = ^upd_pc[1:0];

  assign w_flushLast  = (r_flushCnt == {IDX_W{1'b1}});
  assign busy         = (r_state != IDLE);
  assign flush_done   = r_flushDone;
  assign update_index = r_index;

  // Next-state decode plus the handshake and write-port outputs.
  always_comb begin
    w_nextState  = r_state;
    upd_ready    = 1'b0;
    w_accept     = 1'b0;
    w_startFlush = 1'b0;
    write_enable = 1'b0;
    write_index  = '0;
    write_set    = '0;
    case (r_state)
      IDLE: begin
        if (r_flushPend || flush_req) begin
          w_nextState  = FLUSH;
          w_startFlush = 1'b1;
        end else begin
          upd_ready = 1'b1;
          if (upd_valid) begin
            w_accept    = 1'b1;
            w_nextState = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        w_nextState = w_needWrite ? WRITE : IDLE;
      end
      WRITE: begin
        write_enable = 1'b1;
        write_index  = r_writeIndex;
        write_set    = r_writeSet;
        w_nextState  = IDLE;
      end
      FLUSH: begin
        write_enable = 1'b1;
        write_index  = r_flushCnt;
        if (w_flushLast) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Read-modify-write of the looked-up set: hit update or miss allocation.
  always_comb begin
    w_way0      = update_set[63:0];
    w_way1      = update_set[127:64];
    w_hit0      = w_way0[63] && (w_way0[34 +: TAG_W] == r_tag);
    w_hit1      = w_way1[63] && (w_way1[34 +: TAG_W] == r_tag);
    w_needWrite = 1'b0;
    w_writeWay  = 1'b0;
    w_oldEntry  = w_way0;
    w_ctr       = CTR_INIT;
    w_newTarget = r_target;
    w_newEntry  = '0;
    w_newSet    = update_set;
    if (w_hit0 || w_hit1) begin
      w_needWrite = 1'b1;
      w_writeWay  = !w_hit0;
      w_oldEntry  = w_hit0 ? w_way0 : w_way1;
      w_ctr       = w_oldEntry[62:61];
      if (r_taken) begin
        w_ctr = (w_ctr == 2'd3) ? 2'd3 : w_ctr + 2'd1;
      end else begin
        w_ctr = (w_ctr == 2'd0) ? 2'd0 : w_ctr - 2'd1;
      end
      w_newTarget = r_taken ? r_target : w_oldEntry[31:0];
    end else if (r_taken) begin
      w_needWrite = 1'b1;
      if (!w_way0[63]) begin
        w_writeWay = 1'b0;
      end else if (!w_way1[63]) begin
        w_writeWay = 1'b1;
      end else begin
        w_writeWay = w_way0[32];
      end
    end
    w_newEntry = {1'b1, w_ctr, r_tag, 2'b00, w_newTarget};
    if (w_writeWay) begin
      w_newSet[127:64] = w_newEntry;
      w_newSet[32]     = 1'b0;
    end else begin
      w_newSet[63:0]   = w_newEntry;
      w_newSet[32]     = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the resolved branch when the handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_taken  <= 1'b0;
    end else if (w_accept) begin
      r_index  <= upd_pc[2 +: IDX_W];
      r_tag    <= upd_pc[31 -: TAG_W];
      r_target <= upd_target;
      r_taken  <= upd_taken;
    end
  end

  // Hold the merged set for the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_writeIndex <= '0;
      r_writeSet   <= '0;
    end else if (r_state == LOOKUP) begin
      r_writeIndex <= r_index;
      r_writeSet   <= w_newSet;
    end
  end

  // Flush walk counter, deferred-flush flag and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flushCnt  <= '0;
      r_flushPend <= 1'b0;
      r_flushDone <= 1'b0;
    end else begin
      r_flushDone <= (r_state == FLUSH) && w_flushLast;
      if (w_startFlush) begin
        r_flushCnt  <= '0;
        r_flushPend <= 1'b0;
      end else begin
        if (r_state == FLUSH) begin
          r_flushCnt <= r_flushCnt + 1'b1;
        end
        if (flush_req && ((r_state == LOOKUP) || (r_state == WRITE))) begin
          r_flushPend <= 1'b1;
        end
      end
    end
  end

endmodule
